// File: rtl/mem_stage_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module  : mem_stage_if
// Brief   : Request/grant/ready bus between the MEM stage and the memory system.
// Rev     : 1.0
// -----------------------------------------------------------------------------
interface mem_stage_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 30
);
  logic              req_;
  logic              grnt_;
  logic              as_;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] wr_data;
  logic [WORD_W-1:0] rd_data;
  logic              rdy_;

  modport master (
    output req_, as_, rw, addr, wr_data,
    input  grnt_, rd_data, rdy_
  );

  modport slave (
    input  req_, as_, rw, addr, wr_data,
    output grnt_, rd_data, rdy_
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module  : mem_stage
// Brief   : MEM pipeline stage: load/store bus master, misalignment tagging and
//           the MEM/WB pipeline register.
// Rev     : 1.0
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int         WORD_W          = 32,
  parameter int         ADDR_W          = 30,
  parameter logic [2:0] MISS_ALIGN_CODE = 3'h4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_en,
  input  logic              ex_br_flag,
  input  logic [2:0]        ex_exp_code,
  input  logic [1:0]        ex_mem_op,
  input  logic [WORD_W-1:0] ex_mem_wr_data,
  input  logic [1:0]        ex_ctrl_op,
  input  logic [4:0]        ex_dst_addr,
  input  logic              ex_gpr_we_,
  input  logic [WORD_W-1:0] ex_data,
  input  logic              stall,
  input  logic              flush,
  output logic              busy,
  mem_stage_if.master       bus,
  output logic [ADDR_W-1:0] mem_pc,
  output logic              mem_en,
  output logic              mem_br_flag,
  output logic [2:0]        mem_exp_code,
  output logic [1:0]        mem_ctrl_op,
  output logic [4:0]        mem_dst_addr,
  output logic              mem_gpr_we_,
  output logic [WORD_W-1:0] mem_out
);

  localparam logic [1:0] c_OP_LDW = 2'd1;
  localparam logic [1:0] c_OP_STW = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_ACCESS = 2'd2,
    S_WAIT   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] rd_buf_q, rd_buf_d;

  logic [ADDR_W-1:0] mem_pc_q, mem_pc_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_br_flag_q, mem_br_flag_d;
  logic [2:0]        mem_exp_code_q, mem_exp_code_d;
  logic [1:0]        mem_ctrl_op_q, mem_ctrl_op_d;
  logic [4:0]        mem_dst_addr_q, mem_dst_addr_d;
  logic              mem_gpr_we_q, mem_gpr_we_d;
  logic [WORD_W-1:0] mem_out_q, mem_out_d;

  logic              w_is_ld, w_is_st, w_is_mem, w_misalign, w_start;
  logic [WORD_W-1:0] w_ld_data;

  assign w_is_ld    = (ex_mem_op == c_OP_LDW);
  assign w_is_st    = (ex_mem_op == c_OP_STW);
  assign w_is_mem   = w_is_ld | w_is_st;
  assign w_misalign = w_is_mem & (ex_data[1:0] != 2'b00);
  assign w_start    = ex_en & w_is_mem & (ex_exp_code == 3'h0) &
                      (ex_data[1:0] == 2'b00) & ~flush;
  // Once parked in WAIT the bus data is gone, so the buffered copy is used.
  assign w_ld_data  = (state_q == S_WAIT) ? rd_buf_q : bus.rd_data;

  always_comb begin
    state_d     = state_q;
    rd_buf_d    = rd_buf_q;
    busy        = 1'b0;
    bus.req_    = 1'b1;
    bus.as_     = 1'b1;
    bus.rw      = 1'b1;
    bus.addr    = '0;
    bus.wr_data = '0;
    case (state_q)
      S_IDLE: begin
        if (w_start) begin
          busy     = 1'b1;
          bus.req_ = 1'b0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        busy = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          bus.req_ = 1'b0;
          if (!bus.grnt_) begin
            bus.as_     = 1'b0;
            bus.rw      = ~w_is_st;
            bus.addr    = ex_data[ADDR_W+1:2];
            bus.wr_data = ex_mem_wr_data;
            state_d     = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        bus.req_    = 1'b0;
        bus.rw      = ~w_is_st;
        bus.addr    = ex_data[ADDR_W+1:2];
        bus.wr_data = ex_mem_wr_data;
        busy        = bus.rdy_;
        if (!bus.rdy_) begin
          rd_buf_d = bus.rd_data;
          state_d  = stall ? S_WAIT : S_IDLE;
        end
      end
      S_WAIT: begin
        if (!stall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_pc_d       = mem_pc_q;
    mem_en_d       = mem_en_q;
    mem_br_flag_d  = mem_br_flag_q;
    mem_exp_code_d = mem_exp_code_q;
    mem_ctrl_op_d  = mem_ctrl_op_q;
    mem_dst_addr_d = mem_dst_addr_q;
    mem_gpr_we_d   = mem_gpr_we_q;
    mem_out_d      = mem_out_q;
    if (!stall) begin
      if (flush) begin
        mem_pc_d       = '0;
        mem_en_d       = 1'b0;
        mem_br_flag_d  = 1'b0;
        mem_exp_code_d = 3'h0;
        mem_ctrl_op_d  = 2'd0;
        mem_dst_addr_d = 5'd0;
        mem_gpr_we_d   = 1'b1;
        mem_out_d      = '0;
      end else begin
        mem_pc_d      = ex_pc;
        mem_en_d      = ex_en;
        mem_br_flag_d = ex_br_flag;
        if (w_misalign) begin
          mem_exp_code_d = MISS_ALIGN_CODE;
          mem_ctrl_op_d  = 2'd0;
          mem_dst_addr_d = 5'd0;
          mem_gpr_we_d   = 1'b1;
          mem_out_d      = '0;
        end else begin
          mem_exp_code_d = ex_exp_code;
          mem_ctrl_op_d  = ex_ctrl_op;
          mem_dst_addr_d = ex_dst_addr;
          mem_gpr_we_d   = ex_gpr_we_;
          mem_out_d      = w_is_ld ? w_ld_data : ex_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rd_buf_q       <= '0;
      mem_pc_q       <= '0;
      mem_en_q       <= 1'b0;
      mem_br_flag_q  <= 1'b0;
      mem_exp_code_q <= 3'h0;
      mem_ctrl_op_q  <= 2'd0;
      mem_dst_addr_q <= 5'd0;
      mem_gpr_we_q   <= 1'b1;
      mem_out_q      <= '0;
    end else begin
      state_q        <= state_d;
      rd_buf_q       <= rd_buf_d;
      mem_pc_q       <= mem_pc_d;
      mem_en_q       <= mem_en_d;
      mem_br_flag_q  <= mem_br_flag_d;
      mem_exp_code_q <= mem_exp_code_d;
      mem_ctrl_op_q  <= mem_ctrl_op_d;
      mem_dst_addr_q <= mem_dst_addr_d;
      mem_gpr_we_q   <= mem_gpr_we_d;
      mem_out_q      <= mem_out_d;
    end
  end

  assign mem_pc       = mem_pc_q;
  assign mem_en       = mem_en_q;
  assign mem_br_flag  = mem_br_flag_q;
  assign mem_exp_code = mem_exp_code_q;
  assign mem_ctrl_op  = mem_ctrl_op_q;
  assign mem_dst_addr = mem_dst_addr_q;
  assign mem_gpr_we_  = mem_gpr_we_q;
  assign mem_out      = mem_out_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module  : tb_mem_stage
// Brief   : Directed self-checking bench for mem_stage.
// Rev     : 1.1
// -----------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] ex_pc;
    logic        ex_en;
    logic        ex_br_flag;
    logic [2:0]  ex_exp_code;
    logic [1:0]  ex_mem_op;
    logic [31:0] ex_mem_wr_data;
    logic [1:0]  ex_ctrl_op;
    logic [4:0]  ex_dst_addr;
    logic        ex_gpr_we_;
    logic [31:0] ex_data;
    logic        ext_stall;
    logic        stall;
    logic        flush;
    logic        busy;
    logic [29:0] mem_pc;
    logic        mem_en;
    logic        mem_br_flag;
    logic [2:0]  mem_exp_code;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic        mem_gpr_we_;
    logic [31:0] mem_out;

    int total = 0;
    int bad   = 0;

    mem_stage_if #(.WORD_W(32), .ADDR_W(30)) bus_if ();

    assign stall = ext_stall | busy;

    mem_stage #(.WORD_W(32), .ADDR_W(30), .MISS_ALIGN_CODE(3'h4)) dut (
        .clk(clk), .rst(rst),
        .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_exp_code(ex_exp_code),
        .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op),
        .ex_dst_addr(ex_dst_addr), .ex_gpr_we_(ex_gpr_we_), .ex_data(ex_data),
        .stall(stall), .flush(flush), .busy(busy), .bus(bus_if),
        .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag), .mem_exp_code(mem_exp_code),
        .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_),
        .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input bit ok);
        total++;
        if (!ok) begin
            bad++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [29:0] pc, input logic en, input logic [1:0] op,
                          input logic [31:0] data, input logic [31:0] wd, input logic [4:0] dst,
                          input logic we_n, input logic [1:0] ctrl, input logic br,
                          input logic [2:0] exc);
        ex_pc = pc; ex_en = en; ex_mem_op = op; ex_data = data; ex_mem_wr_data = wd;
        ex_dst_addr = dst; ex_gpr_we_ = we_n; ex_ctrl_op = ctrl; ex_br_flag = br; ex_exp_code = exc;
    endtask

    task automatic nop();
        set_ex(30'h0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 1'b1, 2'd0, 1'b0, 3'h0);
    endtask

    task automatic bus_txn(input int gdly, input int rdly, input logic [31:0] rdat,
                           output int nbusy, output int nas, output logic [29:0] caddr,
                           output logic crw, output logic [31:0] cwd);
        int k;
        int ka;
        bit done;
        k = 0; ka = -1; done = 1'b0; nbusy = 0; nas = 0;
        caddr = '0; crw = 1'b0; cwd = '0;
        while (!done && k < 40) begin
            bus_if.grnt_ = (k >= gdly + 1) ? 1'b0 : 1'b1;
            if (ka >= 0 && k >= ka + 1 + rdly) begin
                bus_if.rdy_ = 1'b0; bus_if.rd_data = rdat;
            end else begin
                bus_if.rdy_ = 1'b1; bus_if.rd_data = 32'h0BAD0BAD;
            end
            #1;
            if (busy) nbusy++;
            if (!bus_if.as_) begin
                nas++; ka = k; caddr = bus_if.addr; crw = bus_if.rw; cwd = bus_if.wr_data;
            end
            if (!bus_if.rdy_) done = 1'b1;
            tick();
            k++;
        end
        bus_if.grnt_ = 1'b1;
        bus_if.rdy_  = 1'b1;
        chk("txn_done", done === 1'b1);
    endtask

    int          nb, na;
    logic [29:0] ca;
    logic        crw;
    logic [31:0] cwd;

    initial begin
        rst = 1'b1; ext_stall = 1'b0; flush = 1'b0; nop();
        bus_if.grnt_ = 1'b1; bus_if.rdy_ = 1'b1; bus_if.rd_data = 32'h0;
        #2;
        chk("rst_mem_en", mem_en === 1'b0);
        chk("rst_mem_we", mem_gpr_we_ === 1'b1);
        chk("rst_mem_out", mem_out === 32'h0);
        chk("rst_mem_pc", mem_pc === 30'h0);
        chk("rst_req", bus_if.req_ === 1'b1);
        chk("rst_as", bus_if.as_ === 1'b1);
        chk("rst_addr", bus_if.addr === 30'h0);
        tick();
        rst = 1'b0;

        set_ex(30'h333, 1'b1, 2'd0, 32'hCAFEF00D, 32'h0, 5'd7, 1'b0, 2'd1, 1'b0, 3'h0);
        #1;
        chk("alu_busy", busy === 1'b0);
        chk("alu_req", bus_if.req_ === 1'b1);
        tick();
        chk("alu_out", mem_out === 32'hCAFEF00D);
        chk("alu_pc", mem_pc === 30'h333);
        chk("alu_dst", mem_dst_addr === 5'd7);
        chk("alu_ctrl", mem_ctrl_op === 2'd1);
        chk("alu_we", mem_gpr_we_ === 1'b0);

        ext_stall = 1'b1;
        set_ex(30'h444, 1'b1, 2'd0, 32'h55AA55AA, 32'h0, 5'd8, 1'b0, 2'd0, 1'b0, 3'h0);
        tick();
        chk("stall_hold_out", mem_out === 32'hCAFEF00D);
        chk("stall_hold_pc", mem_pc === 30'h333);
        ext_stall = 1'b0;

        set_ex(30'h345, 1'b1, 2'd3, 32'h00000010, 32'h0, 5'd1, 1'b0, 2'd0, 1'b0, 3'h0);
        #1;
        chk("rsv_busy", busy === 1'b0);
        tick();
        chk("rsv_out", mem_out === 32'h00000010);

        set_ex(30'h111, 1'b1, 2'd1, 32'h00000100, 32'h0, 5'd5, 1'b0, 2'd2, 1'b1, 3'h0);
        bus_txn(0, 0, 32'hDEADBEEF, nb, na, ca, crw, cwd);
        nop();
        chk("ld_busy_cyc", nb === 2);
        chk("ld_as_cyc", na === 1);
        chk("ld_addr", ca === 30'h40);
        chk("ld_rw", crw === 1'b1);
        chk("ld_out", mem_out === 32'hDEADBEEF);
        chk("ld_we", mem_gpr_we_ === 1'b0);
        chk("ld_pc", mem_pc === 30'h111);
        chk("ld_br", mem_br_flag === 1'b1);
        #1;
        chk("ld_req_released", bus_if.req_ === 1'b1);

        set_ex(30'h222, 1'b1, 2'd2, 32'h00000204, 32'h12345678, 5'd0, 1'b1, 2'd0, 1'b0, 3'h0);
        bus_txn(3, 2, 32'h0, nb, na, ca, crw, cwd);
        nop();
        chk("st_busy_cyc", nb === 7);
        chk("st_as_cyc", na === 1);
        chk("st_rw", crw === 1'b0);
        chk("st_wdata", cwd === 32'h12345678);
        chk("st_addr", ca === 30'h81);
        chk("st_out", mem_out === 32'h00000204);
        chk("st_pc", mem_pc === 30'h222);

        set_ex(30'h0ABC, 1'b1, 2'd1, 32'h00000102, 32'h0, 5'd9, 1'b0, 2'd3, 1'b1, 3'h0);
        #1;
        chk("mis_req", bus_if.req_ === 1'b1);
        chk("mis_busy", busy === 1'b0);
        tick();
        chk("mis_exp", mem_exp_code === 3'h4);
        chk("mis_we", mem_gpr_we_ === 1'b1);
        chk("mis_out", mem_out === 32'h0);
        chk("mis_pc", mem_pc === 30'h0ABC);
        chk("mis_dst", mem_dst_addr === 5'd0);
        chk("mis_ctrl", mem_ctrl_op === 2'd0);

        ext_stall = 1'b1;
        set_ex(30'h555, 1'b1, 2'd1, 32'h00000300, 32'h0, 5'd3, 1'b0, 2'd0, 1'b0, 3'h0);
        bus_txn(0, 0, 32'hA5A50F0F, nb, na, ca, crw, cwd);
        bus_if.rd_data = 32'h0;
        #1;
        chk("wait_busy", busy === 1'b0);
        chk("wait_req", bus_if.req_ === 1'b1);
        chk("wait_hold_out", mem_out === 32'h0);
        tick();
        chk("wait_as", bus_if.as_ === 1'b1);
        ext_stall = 1'b0;
        #1;
        chk("wait_as2", bus_if.as_ === 1'b1);
        tick();
        chk("wait_out", mem_out === 32'hA5A50F0F);
        chk("wait_dst", mem_dst_addr === 5'd3);
        nop();
        #1;
        chk("wait_no_reaccess", bus_if.req_ === 1'b1);

        set_ex(30'h666, 1'b1, 2'd1, 32'h00000400, 32'h0, 5'd2, 1'b0, 2'd0, 1'b0, 3'h0);
        #1;
        chk("frq_busy", busy === 1'b1);
        chk("frq_req0", bus_if.req_ === 1'b0);
        tick();
        flush = 1'b1;
        #1;
        chk("frq_req_dropped", bus_if.req_ === 1'b1);
        chk("frq_as", bus_if.as_ === 1'b1);
        tick();
        chk("frq_idle_busy", busy === 1'b0);
        tick();
        chk("frq_mem_en", mem_en === 1'b0);
        chk("frq_mem_pc", mem_pc === 30'h0);
        flush = 1'b0;

        set_ex(30'h123, 1'b1, 2'd0, 32'h00000099, 32'h0, 5'd6, 1'b0, 2'd0, 1'b0, 3'h0);
        tick();
        chk("fac_pre_en", mem_en === 1'b1);
        set_ex(30'h777, 1'b1, 2'd1, 32'h00000500, 32'h0, 5'd4, 1'b0, 2'd0, 1'b0, 3'h0);
        bus_if.grnt_ = 1'b0;
        tick();
        #1;
        chk("fac_as", bus_if.as_ === 1'b0);
        tick();
        flush = 1'b1;
        #1;
        chk("fac_busy_wait", busy === 1'b1);
        tick();
        bus_if.rdy_ = 1'b0; bus_if.rd_data = 32'h11112222;
        #1;
        chk("fac_busy_rdy", busy === 1'b0);
        tick();
        chk("fac_mem_en", mem_en === 1'b0);
        chk("fac_mem_out", mem_out === 32'h0);
        flush = 1'b0; nop(); bus_if.rdy_ = 1'b1; bus_if.grnt_ = 1'b1;
        #1;
        chk("fac_req_idle", bus_if.req_ === 1'b1);

        set_ex(30'h007, 1'b1, 2'd0, 32'h00000042, 32'h0, 5'd1, 1'b0, 2'd0, 1'b0, 3'h0);
        tick();
        set_ex(30'h008, 1'b1, 2'd1, 32'h00000600, 32'h0, 5'd1, 1'b0, 2'd0, 1'b0, 3'h0);
        bus_if.grnt_ = 1'b0;
        tick();
        tick();
        chk("ra_busy", busy === 1'b1);
        chk("ra_req", bus_if.req_ === 1'b0);
        rst = 1'b1;
        #1;
        chk("ra_mem_en", mem_en === 1'b0);
        chk("ra_mem_out", mem_out === 32'h0);
        chk("ra_mem_we", mem_gpr_we_ === 1'b1);
        chk("ra_as", bus_if.as_ === 1'b1);
        nop(); bus_if.grnt_ = 1'b1; ext_stall = 1'b1;
        #1;
        chk("ra_req_idle", bus_if.req_ === 1'b1);
        tick();
        rst = 1'b0;
        tick();
        chk("ra_post_en", mem_en === 1'b0);
        chk("ra_post_out", mem_out === 32'h0);
        chk("ra_post_req", bus_if.req_ === 1'b1);
        ext_stall = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
